tlp_tx_arbiter: RTL and testbench

- Shares the single PCIe TX channel (64-bit, SOP/EOP framed) between several TLP sources, e.g. read-completion generator (source 0) and DMA write engine (source 1).
- Arbitrates per packet, never per beat: once a source starts a TLP, it owns the channel until its EOP beat is accepted.
- Source 0 has bounded priority so host reads do not time out behind long DMA bursts.
- Sits between the TLP transceiver logic and the PCIe core TX interface.

---
 rtl/tlp_tx_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_tlp_tx_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_arbiter.sv
// Packet-granular arbiter sharing one 64-bit SOP/EOP framed PCIe TX channel
// between up to four TLP sources, with starvation-bounded priority for source 0.
module tlp_tx_arbiter #(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned PRIO_SRC0    = 1,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_QW       = 18
) (
  input  logic                  pcieClk_in,
  input  logic                  pcieReset_n_in,
  input  logic [NUM_SRC*64-1:0] srcData_in,
  input  logic [NUM_SRC-1:0]    srcValid_in,
  input  logic [NUM_SRC-1:0]    srcSOP_in,
  input  logic [NUM_SRC-1:0]    srcEOP_in,
  output logic [NUM_SRC-1:0]    srcReady_out,
  output logic [63:0]           txData_out,
  output logic                  txValid_out,
  input  logic                  txReady_in,
  output logic                  txSOP_out,
  output logic                  txEOP_out,
  output logic [1:0]            grant_out,
  output logic                  busy_out,
  output logic                  frameErr_out
);

  localparam int unsigned DW      = 64;
  localparam int unsigned MAX_SRC = 4;
  localparam int unsigned GW      = 2;
  localparam int unsigned IW      = 3;
  localparam int unsigned PCW     = 4;
  localparam int unsigned BCW     = 5;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_HOLD = 2'd1,
    ST_PKT  = 2'd2
  } state_t;

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               r_active;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_rr_ptr;
  logic [PCW-1:0]     r_prio_cnt;
  logic [BCW-1:0]     r_beat_cnt;
  logic               r_frame_err;

  logic [MAX_SRC-1:0] w_valid_pad;
  logic [MAX_SRC-1:0] w_sop_pad;
  logic [MAX_SRC-1:0] w_eop_pad;
  logic [MAX_SRC-1:0] w_ready_pad;
  logic [DW-1:0]      w_data [MAX_SRC];
  logic [GW-1:0]      w_rr_win;
  logic               w_rr_found;
  logic [IW-1:0]      w_idx;
  logic               w_other_valid;
  logic               w_any_valid;
  logic               w_prio_win;
  logic [GW-1:0]      w_winner;
  logic               w_locked;
  logic [GW-1:0]      w_sel;
  logic               w_tx_valid;
  logic               w_sop;
  logic               w_eop;
  logic               w_fire;
  logic [BCW-1:0]     w_beat_nxt;
  logic               w_err;
  logic [IW-1:0]      w_rr_sum;
  logic [GW-1:0]      w_rr_nxt;
  logic [PCW-1:0]     w_prio_nxt;

  // Asynchronous assert, synchronous release of the internal reset
  always_ff @(posedge pcieClk_in or negedge pcieReset_n_in) begin
    if (!pcieReset_n_in) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n  = r_rst_sync[1];
  assign r_active = r_rst_sync[1];

  // Pad per-source vectors to the maximum source count for uniform indexing
  always_comb begin
    w_valid_pad = MAX_SRC'(srcValid_in);
    w_sop_pad   = MAX_SRC'(srcSOP_in);
    w_eop_pad   = MAX_SRC'(srcEOP_in);
    for (int i = 0; i < MAX_SRC; i++) begin
      w_data[i] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      w_data[i] = srcData_in[i*DW +: DW];
    end
  end

  // Round-robin pick: first valid source at or after the pointer
  always_comb begin
    w_rr_win   = r_rr_ptr;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = IW'(r_rr_ptr) + IW'(k);
      if (w_idx >= IW'(NUM_SRC)) begin
        w_idx = w_idx - IW'(NUM_SRC);
      end
      if (!w_rr_found && w_valid_pad[w_idx[GW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_idx[GW-1:0];
      end
    end
  end

  assign w_other_valid = |w_valid_pad[MAX_SRC-1:1];
  assign w_any_valid   = |w_valid_pad;
  assign w_prio_win    = (PRIO_SRC0 != 0) && w_valid_pad[0] &&
                         ((r_prio_cnt < PCW'(STARVE_LIMIT)) || !w_other_valid);
  assign w_winner      = w_prio_win ? '0 : w_rr_win;
  assign w_locked      = (r_state != ST_ARB);
  assign w_sel         = w_locked ? r_grant : (w_any_valid ? w_winner : r_grant);

  assign w_tx_valid = r_active & w_valid_pad[w_sel];
  assign w_sop      = w_sop_pad[w_sel];
  assign w_eop      = w_eop_pad[w_sel];
  assign w_fire     = w_tx_valid & txReady_in;

  always_comb begin
    w_ready_pad = '0;
    if (r_active) begin
      w_ready_pad[w_sel] = txReady_in;
    end
  end

  assign srcReady_out = w_ready_pad[NUM_SRC-1:0];
  assign txData_out   = w_data[w_sel];
  assign txValid_out  = w_tx_valid;
  assign txSOP_out    = w_sop;
  assign txEOP_out    = w_eop;
  assign grant_out    = r_active ? w_sel : '0;
  assign busy_out     = r_active & (w_locked | w_tx_valid);
  assign frameErr_out = r_frame_err;

  // Beat counter saturates so an unterminated packet never wraps back below the limit
  assign w_beat_nxt = w_sop ? BCW'(1) :
                      ((r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + BCW'(1));

  assign w_err = w_fire & ((!w_sop && (r_state != ST_PKT)) ||
                           (w_sop && (r_state == ST_PKT)) ||
                           (!w_eop && (w_beat_nxt >= BCW'(MAX_QW))));

  assign w_rr_sum   = IW'(w_sel) + IW'(1);
  assign w_rr_nxt   = (w_rr_sum >= IW'(NUM_SRC)) ? '0 : w_rr_sum[GW-1:0];
  assign w_prio_nxt = ((w_sel == '0) && w_other_valid) ?
                      ((r_prio_cnt == '1) ? r_prio_cnt : r_prio_cnt + PCW'(1)) : '0;

  // HOLD: first beat presented but stalled; PKT: a multi-beat packet is open
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_tx_valid && !txReady_in) begin
          w_state_nxt = ST_HOLD;
        end else if (w_fire && w_sop && !w_eop) begin
          w_state_nxt = ST_PKT;
        end
      end
      ST_HOLD: begin
        if (w_fire) begin
          w_state_nxt = w_eop ? ST_ARB : ST_PKT;
        end
      end
      ST_PKT: begin
        if (w_fire && w_eop) begin
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge pcieClk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pcieClk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_prio_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_grant <= w_sel;
      if (w_fire) begin
        r_beat_cnt <= w_beat_nxt;
      end
      if (w_err) begin
        r_frame_err <= 1'b1;
      end
      if (w_fire && w_eop) begin
        r_rr_ptr   <= w_rr_nxt;
        r_prio_cnt <= w_prio_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Self-checking bench for tlp_tx_arbiter: vector table, directed multi-cycle
// sequences, and randomized traffic against a packet-level reference model.
module tb_tlp_tx_arbiter;

  localparam int STARVE = 4;
  localparam int MAXQW  = 18;

  logic         clk;
  logic         rst_n;
  logic [127:0] src_data;
  logic [1:0]   src_valid;
  logic [1:0]   src_sop;
  logic [1:0]   src_eop;
  logic [1:0]   src_ready;
  logic [63:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_sop;
  logic         tx_eop;
  logic [1:0]   grant;
  logic         busy;
  logic         ferr;

  int n_chk;
  int n_err;

  tlp_tx_arbiter #(
    .NUM_SRC(2), .PRIO_SRC0(1), .STARVE_LIMIT(STARVE), .MAX_QW(MAXQW)
  ) dut (
    .pcieClk_in     (clk),
    .pcieReset_n_in (rst_n),
    .srcData_in     (src_data),
    .srcValid_in    (src_valid),
    .srcSOP_in      (src_sop),
    .srcEOP_in      (src_eop),
    .srcReady_out   (src_ready),
    .txData_out     (tx_data),
    .txValid_out    (tx_valid),
    .txReady_in     (tx_ready),
    .txSOP_out      (tx_sop),
    .txEOP_out      (tx_eop),
    .grant_out      (grant),
    .busy_out       (busy),
    .frameErr_out   (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  sop;
    logic [1:0]  eop;
    logic        rdy;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        e_valid;
    logic [1:0]  e_grant;
    logic [1:0]  e_srdy;
    logic        e_busy;
    logic        e_sop;
    logic        e_eop;
    int          e_src;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_valid = 2'b00;
    src_sop   = 2'b00;
    src_eop   = 2'b00;
    src_data  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference model state (packet level)
  int m_owner, m_grant, m_rr, m_pc, m_beats;
  bit m_open, m_err;

  // Random source state
  bit          s_valid [2];
  int          s_left  [2];
  bit          s_first [2];
  logic [63:0] s_dat   [2];
  int          s_seq   [2];

  initial begin
    int q_order[$];
    int exp_order[6];
    int gaps;
    int s0_beat, s1_beat;
    bit s1_on;
    bit seen;

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    tx_ready = 1'b0;
    idle_inputs();

    // v sop eop rdy d0 d1 | valid grant srdy busy sop eop src
    tbl[0] = '{2'b11, 2'b11, 2'b00, 1'b0, 64'hA0, 64'hB0, 1'b1, 2'd0, 2'b00, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = tbl[0];
    tbl[2] = tbl[0];
    tbl[3] = tbl[0];
    tbl[4] = tbl[0];
    tbl[5] = '{2'b11, 2'b11, 2'b00, 1'b1, 64'hA0, 64'hB0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 0};
    tbl[6] = '{2'b11, 2'b10, 2'b01, 1'b1, 64'hA1, 64'hB0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1, 0};
    tbl[7] = '{2'b10, 2'b10, 2'b00, 1'b1, 64'h0,  64'hB0, 1'b1, 2'd1, 2'b10, 1'b1, 1'b1, 1'b0, 1};
    tbl[8] = '{2'b10, 2'b00, 2'b10, 1'b1, 64'h0,  64'hB1, 1'b1, 2'd1, 2'b10, 1'b1, 1'b0, 1'b1, 1};
    tbl[9] = '{2'b00, 2'b00, 2'b00, 1'b1, 64'h0,  64'h0,  1'b0, 2'd1, 2'b10, 1'b0, 1'b0, 1'b0, -1};

    // Outputs held low while reset is asserted, even with requests pending
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    src_valid = 2'b11;
    src_sop = 2'b11;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("rst_txvalid", 64'(tx_valid), 64'd0);
    chk("rst_srdy", 64'(src_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ferr", 64'(ferr), 64'd0);
    do_reset();

    // Table: contested stall, then src0 and src1 packets back to back
    for (int i = 0; i < 10; i++) begin
      src_valid = tbl[i].v;
      src_sop   = tbl[i].sop;
      src_eop   = tbl[i].eop;
      tx_ready  = tbl[i].rdy;
      src_data  = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 64'(tx_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_srdy", i), 64'(src_ready), 64'(tbl[i].e_srdy));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_src >= 0) begin
        chk($sformatf("tbl%0d_sopeop", i), 64'({tx_sop, tx_eop}), 64'({tbl[i].e_sop, tbl[i].e_eop}));
        chk($sformatf("tbl%0d_data", i), tx_data, (tbl[i].e_src == 0) ? tbl[i].d0 : tbl[i].d1);
      end
      tick();
    end

    // 18-beat src1 TLP; src0 requests from beat 3 and must wait for EOP
    do_reset();
    tx_ready = 1'b1;
    for (int b = 1; b <= 18; b++) begin
      src_valid = {1'b1, (b >= 3)};
      src_sop   = {(b == 1), 1'b1};
      src_eop   = {(b == 18), 1'b0};
      src_data  = {64'h1000 + 64'(b), 64'h2000};
      @(negedge clk);
      chk($sformatf("long_b%0d_grant", b), 64'(grant), 64'd1);
      chk($sformatf("long_b%0d_valid", b), 64'(tx_valid), 64'd1);
      chk($sformatf("long_b%0d_sopeop", b), 64'({tx_sop, tx_eop}), 64'({(b == 1), (b == 18)}));
      chk($sformatf("long_b%0d_srdy", b), 64'(src_ready), 64'b10);
      chk($sformatf("long_b%0d_data", b), tx_data, 64'h1000 + 64'(b));
      tick();
    end
    src_valid = 2'b01;
    src_sop   = 2'b01;
    src_eop   = 2'b00;
    src_data  = {64'h0, 64'h2000};
    @(negedge clk);
    chk("after_long_grant", 64'(grant), 64'd0);
    chk("after_long_valid_sop", 64'({tx_valid, tx_sop}), 64'b11);
    tick();
    src_sop  = 2'b00;
    src_eop  = 2'b01;
    src_data = {64'h0, 64'h2001};
    @(negedge clk);
    chk("src0_eop_grant", 64'(grant), 64'd0);
    chk("src0_eop_data", tx_data, 64'h2001);
    chk("long_ferr", 64'(ferr), 64'd0);
    tick();
    idle_inputs();

    // Starvation bound: src0 streams 2-beat TLPs while src1 waits
    do_reset();
    tx_ready = 1'b1;
    s0_beat = 0;
    s1_beat = 0;
    s1_on = 1'b1;
    gaps = 0;
    exp_order = '{0, 0, 0, 0, 1, 0};
    for (int c = 0; c < 40 && q_order.size() < 6; c++) begin
      src_valid = {s1_on, 1'b1};
      src_sop   = {(s1_beat == 0), (s0_beat == 0)};
      src_eop   = {(s1_beat == 1), (s0_beat == 1)};
      @(negedge clk);
      if (!tx_valid) gaps++;
      if (tx_valid && tx_ready && tx_sop) q_order.push_back(int'(grant));
      if (src_ready[0]) s0_beat = 1 - s0_beat;
      if (src_ready[1] && s1_on) begin
        s1_beat++;
        if (s1_beat == 2) s1_on = 1'b0;
      end
      tick();
    end
    chk("starve_count", 64'(q_order.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < q_order.size()) chk($sformatf("starve_pkt%0d", i), 64'(q_order[i]), 64'(exp_order[i]));
    end
    chk("starve_gaps", 64'(gaps), 64'd0);
    idle_inputs();

    // Unlocked beat without SOP: forwarded, sticky error until reset
    do_reset();
    tx_ready  = 1'b1;
    src_valid = 2'b10;
    src_sop   = 2'b00;
    src_eop   = 2'b10;
    src_data  = {64'hBAD, 64'h0};
    @(negedge clk);
    chk("nosop_fwd_valid", 64'(tx_valid), 64'd1);
    chk("nosop_fwd_data", tx_data, 64'hBAD);
    chk("nosop_ferr_same_cycle", 64'(ferr), 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("nosop_ferr_set", 64'(ferr), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("nosop_ferr_sticky", 64'(ferr), 64'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("nosop_ferr_reset", 64'(ferr), 64'd0);
    rst_n = 1'b1;

    // Packet with no EOP: error exactly when beat MAX_QW is accepted
    do_reset();
    tx_ready = 1'b1;
    for (int b = 1; b <= MAXQW; b++) begin
      src_valid = 2'b10;
      src_sop   = {(b == 1), 1'b0};
      src_eop   = 2'b00;
      src_data  = {64'h3000 + 64'(b), 64'h0};
      @(negedge clk);
      if (b == MAXQW) chk("len_ferr_before_limit", 64'(ferr), 64'd0);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk("len_ferr_at_limit", 64'(ferr), 64'd1);

    // Reset pulsed during beat 5 of a src1 TLP; pending src0 wins afterwards
    do_reset();
    tx_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      src_valid = 2'b10;
      src_sop   = {(b == 1), 1'b0};
      src_eop   = 2'b00;
      src_data  = {64'h4000 + 64'(b), 64'h0};
      tick();
    end
    src_valid = 2'b11;
    src_sop   = 2'b01;
    src_eop   = 2'b00;
    src_data  = {64'h4005, 64'h5000};
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_txvalid", 64'(tx_valid), 64'd0);
    chk("midrst_srdy", 64'(src_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_sop", 64'(tx_sop), 64'd1);
        chk("midrst_data", tx_data, 64'h5000);
      end
      tick();
    end
    chk("midrst_regrant_seen", 64'(seen), 64'd1);
    idle_inputs();

    // Randomized traffic against the packet-level reference model
    do_reset();
    m_owner = -1; m_grant = 0; m_rr = 0; m_pc = 0; m_beats = 0;
    m_open = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; s_left[i] = 0; s_first[i] = 1'b0; s_dat[i] = '0; s_seq[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      int sel;
      bit e_valid, fire, sop, eop;
      logic [1:0] v;
      logic [1:0] e_srdy;

      for (int i = 0; i < 2; i++) begin
        if (!s_valid[i]) begin
          if (s_left[i] == 0 && ($urandom % 3) == 0) begin
            s_left[i] = $urandom_range(1, 6);
            s_first[i] = 1'b1;
          end
          if (s_left[i] > 0 && ($urandom % 4) != 0) begin
            s_valid[i] = 1'b1;
            s_dat[i] = {32'(i), 32'(s_seq[i])};
            s_seq[i]++;
          end
        end
      end
      src_valid = {s_valid[1], s_valid[0]};
      src_sop   = {s_valid[1] & s_first[1], s_valid[0] & s_first[0]};
      src_eop   = {s_valid[1] & (s_left[1] == 1), s_valid[0] & (s_left[0] == 1)};
      src_data  = {s_dat[1], s_dat[0]};
      tx_ready  = (($urandom % 4) != 0);
      v = src_valid;

      if (m_owner >= 0) sel = m_owner;
      else if (v == 2'b00) sel = m_grant;
      else if (v[0] && (m_pc < STARVE || !v[1])) sel = 0;
      else begin
        sel = -1;
        for (int k = 0; k < 2; k++) begin
          if (sel < 0 && v[(m_rr + k) % 2]) sel = (m_rr + k) % 2;
        end
      end
      e_valid = v[sel];
      e_srdy = 2'b00;
      e_srdy[sel] = tx_ready;
      sop = src_sop[sel];
      eop = src_eop[sel];
      fire = e_valid && tx_ready;

      @(negedge clk);
      chk("rnd_valid", 64'(tx_valid), 64'(e_valid));
      chk("rnd_grant", 64'(grant), 64'(sel));
      chk("rnd_srdy", 64'(src_ready), 64'(e_srdy));
      chk("rnd_busy", 64'(busy), 64'((m_owner >= 0) || e_valid));
      chk("rnd_ferr", 64'(ferr), 64'(m_err));
      if (e_valid) begin
        chk("rnd_data", tx_data, s_dat[sel]);
        chk("rnd_sopeop", 64'({tx_sop, tx_eop}), 64'({sop, eop}));
      end

      if (fire) begin
        m_beats = sop ? 1 : ((m_beats < 31) ? m_beats + 1 : 31);
        if ((!m_open && !sop) || (m_open && sop) || (!eop && m_beats >= MAXQW)) m_err = 1'b1;
      end
      if (fire && eop) begin
        m_owner = -1;
        m_open = 1'b0;
        m_rr = (sel + 1) % 2;
        if (sel == 0) m_pc = v[1] ? ((m_pc < 15) ? m_pc + 1 : 15) : 0;
        else m_pc = 0;
      end else if (fire && (sop || m_owner >= 0)) begin
        m_owner = sel;
        m_open = 1'b1;
      end else if (e_valid && !fire) begin
        m_owner = sel;
      end
      m_grant = sel;

      for (int i = 0; i < 2; i++) begin
        if (s_valid[i] && e_srdy[i]) begin
          s_valid[i] = 1'b0;
          s_first[i] = 1'b0;
          s_left[i]--;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
